// File: rtl/alu_pkg.sv
// Purpose: shared constants for the ALU flag / condition-code interface.
// Contents: flag bit positions, ARM-style condition codes, result-buffer states.
// Ports: none (package).
package alu_pkg;

  // Bit positions inside the 4-bit flag vector.
  localparam int FLAG_V = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 3;

  // Condition codes.
  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  // One-entry result buffer occupancy.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } buf_state_e;

endpackage

// File: rtl/cond_eval.sv
// Purpose: combinational evaluation of a condition code against a flag vector.
// Latency: zero (pure combinational), no backpressure.
// Ports: flags_i (V,N,Z,C at FLAG_* positions), code_i (condition), pass_o (1 = true).
module cond_eval
  import alu_pkg::*;
(
  input  logic [3:0] flags_i,
  input  logic [3:0] code_i,
  output logic       pass_o
);

  logic n, z, c, v;

  assign n = flags_i[FLAG_N];
  assign z = flags_i[FLAG_Z];
  assign c = flags_i[FLAG_C];
  assign v = flags_i[FLAG_V];

  always_comb begin
    pass_o = 1'b0;
    case (code_i)
      COND_EQ: pass_o = z;
      COND_NE: pass_o = ~z;
      COND_CS: pass_o = c;
      COND_CC: pass_o = ~c;
      COND_MI: pass_o = n;
      COND_PL: pass_o = ~n;
      COND_VS: pass_o = v;
      COND_VC: pass_o = ~v;
      COND_HI: pass_o = c & ~z;
      COND_LS: pass_o = ~c | z;
      COND_GE: pass_o = (n == v);
      COND_LT: pass_o = (n != v);
      COND_GT: pass_o = ~z & (n == v);
      COND_LE: pass_o = z | (n != v);
      COND_AL: pass_o = 1'b1;
      default: pass_o = 1'b0; // NV: reserved, never passes
    endcase
  end

endmodule

// File: rtl/cond_flag_unit.sv
// Purpose: architectural status register plus condition evaluation with a one-entry result buffer.
// Latency: result valid one cycle after query acceptance; flag writes take effect at the next edge.
// Backpressure: cond_ready = buffer empty | pass_ready; flag writes are never stalled.
// Ports: clk/rst_n; flags_in/flags_we (ALU flag write); cond_valid/cond_code/cond_ready (query);
//        pass_valid/pass/pass_ready (result); flags_out (status register).
module cond_flag_unit
  import alu_pkg::*;
#(
  parameter bit         FORWARD     = 1'b1,
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] flags_in,
  input  logic       flags_we,
  input  logic       cond_valid,
  input  logic [3:0] cond_code,
  output logic       cond_ready,
  output logic       pass_valid,
  output logic       pass,
  input  logic       pass_ready,
  output logic [3:0] flags_out
);

  logic [3:0] flags_q, flags_d;
  buf_state_e state_q;
  logic       pass_q;
  logic [3:0] eval_flags;
  logic       eval_pass;
  logic       accept;

  assign cond_ready = (state_q == ST_EMPTY) | pass_ready;
  assign accept     = cond_valid & cond_ready;

  // With forwarding, a query landing with a flag write sees the incoming flags.
  assign eval_flags = (FORWARD && flags_we) ? flags_in : flags_q;
  assign flags_d    = flags_we ? flags_in : flags_q;

  cond_eval u_cond_eval (
    .flags_i (eval_flags),
    .code_i  (cond_code),
    .pass_o  (eval_pass)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flags_q <= RESET_FLAGS;
    else        flags_q <= flags_d;
  end

  // Result buffer: pass is captured at acceptance and never re-evaluated while held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      pass_q  <= 1'b0;
    end else if (state_q == ST_EMPTY) begin
      if (accept) begin
        state_q <= ST_FULL;
        pass_q  <= eval_pass;
      end
    end else if (pass_ready) begin
      if (accept) begin
        pass_q  <= eval_pass;
      end else begin
        state_q <= ST_EMPTY;
        pass_q  <= 1'b0;
      end
    end
  end

  assign pass_valid = (state_q == ST_FULL);
  assign pass       = pass_q;
  assign flags_out  = flags_q;

endmodule
